// File: rtl/led_link_rx.sv
// rtl/led_link_rx.sv - serial LED link receiver: 1-bit stream to RGB565 pixels with column-major position
// Optional frame CRC-16/CCITT built when LED_LINK_RX_FRAME_CRC_EN is defined; otherwise FRAME_CRC is 0.
module led_link_rx #(
  parameter int H_PIX = 320,
  parameter int V_PIX = 240,
  parameter int PIX_W = 16,
  parameter int X_W   = 9,
  parameter int Y_W   = 8
) (
  input  logic             LED_CLK,
  input  logic             W_RST,
  input  logic             LINK_RESET,
  input  logic             DATA,
  input  logic             PIX_READY,
  output logic             PIX_VALID,
  output logic [PIX_W-1:0] PIX_DATA,
  output logic [X_W-1:0]   PIX_X,
  output logic [Y_W-1:0]   PIX_Y,
  output logic             FRAME_DONE,
  output logic [15:0]      FRAME_CNT,
  output logic [7:0]       ABORT_CNT,
  output logic             OVERFLOW,
  output logic [15:0]      FRAME_CRC
);

  localparam int BC_W = $clog2(PIX_W);
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(PIX_W - 1);
  localparam logic [X_W-1:0]  X_LAST  = X_W'(H_PIX - 1);
  localparam logic [Y_W-1:0]  Y_LAST  = Y_W'(V_PIX - 1);

  logic [BC_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [PIX_W-1:0] shift_q, shift_d;
  logic [X_W-1:0]   x_q, x_d;
  logic [Y_W-1:0]   y_q, y_d;
  logic             valid_q, valid_d;
  logic [PIX_W-1:0] data_q, data_d;
  logic [X_W-1:0]   px_q, px_d;
  logic [Y_W-1:0]   py_q, py_d;
  logic             done_q, done_d;
  logic [15:0]      frame_cnt_q, frame_cnt_d;
  logic [7:0]       abort_cnt_q, abort_cnt_d;
  logic             ovf_q, ovf_d;
  logic [PIX_W-1:0] pix_word;
  logic             frame_end;

  always_comb begin
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    x_d         = x_q;
    y_d         = y_q;
    valid_d     = valid_q;
    data_d      = data_q;
    px_d        = px_q;
    py_d        = py_q;
    done_d      = 1'b0;
    frame_cnt_d = frame_cnt_q;
    abort_cnt_d = abort_cnt_q;
    ovf_d       = ovf_q;
    frame_end   = 1'b0;
    pix_word    = shift_q;
    pix_word[PIX_W-1] = DATA;

    if (valid_q && PIX_READY) valid_d = 1'b0;

    if (LINK_RESET) begin
      // bit_cnt is zero after the first cycle, so a long assertion counts once
      bit_cnt_d = '0;
      shift_d   = '0;
      x_d       = '0;
      y_d       = '0;
      if (bit_cnt_q != '0 && abort_cnt_q != 8'hFF) abort_cnt_d = abort_cnt_q + 8'd1;
    end else begin
      shift_d[bit_cnt_q] = DATA;
      if (bit_cnt_q == BC_LAST) begin
        bit_cnt_d = '0;
        if (y_q == Y_LAST) begin
          y_d = '0;
          if (x_q == X_LAST) begin
            x_d         = '0;
            frame_end   = 1'b1;
            frame_cnt_d = frame_cnt_q + 16'd1;
          end else begin
            x_d = x_q + 1'b1;
          end
        end else begin
          y_d = y_q + 1'b1;
        end
        // A held word that is not being taken this cycle wins over the new one
        if (!valid_q || PIX_READY) begin
          valid_d = 1'b1;
          data_d  = pix_word;
          px_d    = x_q;
          py_d    = y_q;
          done_d  = frame_end;
        end else begin
          ovf_d = 1'b1;
        end
      end else begin
        bit_cnt_d = bit_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge LED_CLK) begin
    if (W_RST) begin
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      x_q         <= '0;
      y_q         <= '0;
      valid_q     <= 1'b0;
      data_q      <= '0;
      px_q        <= '0;
      py_q        <= '0;
      done_q      <= 1'b0;
      frame_cnt_q <= '0;
      abort_cnt_q <= '0;
      ovf_q       <= 1'b0;
    end else begin
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      x_q         <= x_d;
      y_q         <= y_d;
      valid_q     <= valid_d;
      data_q      <= data_d;
      px_q        <= px_d;
      py_q        <= py_d;
      done_q      <= done_d;
      frame_cnt_q <= frame_cnt_d;
      abort_cnt_q <= abort_cnt_d;
      ovf_q       <= ovf_d;
    end
  end

`ifdef LED_LINK_RX_FRAME_CRC_EN
  logic [15:0] crc_q, crc_d, crc_next, fcrc_q, fcrc_d;

  always_comb begin
    crc_next = {crc_q[14:0], 1'b0} ^ ((crc_q[15] ^ DATA) ? 16'h1021 : 16'h0000);
    crc_d    = crc_q;
    fcrc_d   = fcrc_q;
    if (LINK_RESET) begin
      crc_d = 16'hFFFF;
    end else if (frame_end) begin
      fcrc_d = crc_next;
      crc_d  = 16'hFFFF;
    end else begin
      crc_d = crc_next;
    end
  end

  always_ff @(posedge LED_CLK) begin
    if (W_RST) begin
      crc_q  <= 16'hFFFF;
      fcrc_q <= '0;
    end else begin
      crc_q  <= crc_d;
      fcrc_q <= fcrc_d;
    end
  end

  assign FRAME_CRC = fcrc_q;
`else
  assign FRAME_CRC = '0;
`endif

  assign PIX_VALID  = valid_q;
  assign PIX_DATA   = data_q;
  assign PIX_X      = px_q;
  assign PIX_Y      = py_q;
  assign FRAME_DONE = done_q;
  assign FRAME_CNT  = frame_cnt_q;
  assign ABORT_CNT  = abort_cnt_q;
  assign OVERFLOW   = ovf_q;

endmodule

// File: doc/led_link_rx.md
Name: led_link_rx

Overview:
- Receiving end of the serial monitor link, clocked by LED_CLK.
- Deserialises the 1-bit DATA stream into 16-bit RGB565 pixels.
- Tracks the column-major scan position: y runs fastest, then x.
- Presents each pixel with coordinates on a valid/ready write port for a framebuffer or checker model, plus frame and error status.

Parameters:
- H_PIX, 320, columns per frame (x range 0..H_PIX-1)
- V_PIX, 240, rows per column (y range 0..V_PIX-1)
- PIX_W, 16, bits per pixel
- X_W, 9, width of the x coordinate
- Y_W, 8, width of the y coordinate

Ports:
- LED_CLK  in  1  link clock; all logic on the rising edge
- W_RST  in  1  block reset
- LINK_RESET  in  1  link-level reset from the transmitter; active-high
- DATA  in  1  serial pixel bit, sampled every LED_CLK edge
- PIX_READY  in  1  sink accepts the pixel this cycle
- PIX_VALID  out  1  pixel word available
- PIX_DATA  out  PIX_W  received pixel
- PIX_X  out  X_W  column of PIX_DATA
- PIX_Y  out  Y_W  row of PIX_DATA
- FRAME_DONE  out  1  one-cycle pulse with the last pixel of a frame
- FRAME_CNT  out  16  completed frames, wraps at 0xFFFF->0
- ABORT_CNT  out  8  pixels truncated by LINK_RESET; saturates at 255
- OVERFLOW  out  1  sticky; a pixel was dropped
- FRAME_CRC  out  16  CRC of the last complete frame

Behaviour:
- Reset: W_RST is synchronous and active-high; the clock is LED_CLK.
  - W_RST clears all state: bit_cnt, shift register, x, y, counters and flags.
  - All outputs read 0 the cycle after W_RST is sampled high.
  - W_RST takes priority over every other input.
- Bit order: bits arrive LSB first. With LINK_RESET low, DATA is written to shift[bit_cnt] and bit_cnt increments.
- Pixel completion: when bit_cnt==PIX_W-1, the pixel is complete at that edge and bit_cnt wraps to 0.
  - The full word plus the current (x,y) is registered to PIX_DATA/PIX_X/PIX_Y, and PIX_VALID=1.
  - Visible one cycle after the 16th bit is sampled.
  - Steady-state throughput: one pixel per PIX_W cycles.
- Position advance on each completed pixel, dropped ones included:
  - y++.
  - If y==V_PIX-1: y=0 and x++.
  - If also x==H_PIX-1: x=0, FRAME_DONE=1 for exactly the cycle PIX_VALID rises for that pixel, FRAME_CNT++.
- Handshake:
  - Transfer occurs when PIX_VALID&&PIX_READY.
  - PIX_DATA/PIX_X/PIX_Y are held stable while PIX_VALID&&!PIX_READY.
  - PIX_VALID falls the cycle after a transfer unless a new pixel completes in that same cycle.
  - Transfer and completion in the same cycle: the old pixel is accepted, the new one is loaded, PIX_VALID stays 1, no overflow.
  - Completion while PIX_VALID&&!PIX_READY: the new pixel is discarded, the held pixel is kept, OVERFLOW=1. OVERFLOW clears only on W_RST.
- LINK_RESET high, on each cycle it is sampled:
  - bit_cnt=0, shift cleared, x=y=0, DATA ignored.
  - If bit_cnt!=0 on the first cycle of the assertion, ABORT_CNT++ (saturating) and the partial pixel is discarded.
  - Counts once per assertion, not per cycle.
  - A pending PIX_VALID word is kept and may still transfer.
  - FRAME_CNT and OVERFLOW are unaffected.
  - The first bit after deassertion is pixel bit 0 at position (0,0).
- FRAME_DONE is never asserted for a frame cut short by LINK_RESET.

Optional Feature:
- Macro: LED_LINK_RX_FRAME_CRC_EN.
- Defined:
  - A running CRC-16/CCITT (poly 0x1021, init 0xFFFF, no reflect, no xorout) is updated on every accepted DATA bit, in arrival order.
  - On FRAME_DONE the final value, including the last bit, is latched to FRAME_CRC and the running CRC reinitialises to 0xFFFF.
  - LINK_RESET and W_RST reinitialise the running CRC. W_RST also clears FRAME_CRC.
- Not defined: no CRC logic is built; FRAME_CRC is constant 0.

Test Plan:
1. W_RST 2 cycles, LINK_RESET low, send 0xA5C3 LSB first, PIX_READY=1 -> PIX_VALID=1 exactly one cycle, starting the cycle after the 16th bit; PIX_DATA=0xA5C3, PIX_X=0, PIX_Y=0; OVERFLOW=0.
2. Stream 241 pixels (pixel i = i), PIX_READY=1 -> pixel 240 reported at X=1, Y=0 with PIX_DATA=0x00F0; pixel 239 at X=0, Y=239.
3. Full frame of 76800 pixels, then one more -> FRAME_DONE single pulse with pixel (319,239); FRAME_CNT=1; next pixel at (0,0).
4. PIX_READY=0 for 20 cycles spanning two completions, pixels 0x1111 and 0x2222 -> PIX_DATA held at 0x1111; 0x2222 dropped; OVERFLOW=1; next pixel reported at Y=2.
5. LINK_RESET pulsed 3 cycles after 7 bits of a pixel -> ABORT_CNT=1, no PIX_VALID; the next full pixel appears at (0,0); a second pulse with bit_cnt=0 leaves ABORT_CNT=1.
6. H_PIX=1, V_PIX=1, macro defined, pixels 0x0000 then 0xFFFF -> FRAME_CRC matches the bench bitwise CRC-16/CCITT model for each frame; with the macro undefined, FRAME_CRC stays 0.
